// File: rtl/led_stretch_pwm_if.sv
`default_nettype none
// ============================================================================
// Module   : led_stretch_pwm_if
// Brief    : LED bus between the CPU core and the LED output stage.
// Revision : 1.0
// ============================================================================
interface led_stretch_pwm_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0] led_in;
    logic [WIDTH-1:0] led_out;

    modport master (output led_in, input led_out);
    modport slave  (input led_in, output led_out);
endinterface
`default_nettype wire

// File: rtl/led_stretch_pwm.sv
`default_nettype none
// ============================================================================
// Module   : led_stretch_pwm
// Brief    : Registered LED output stage with per-bit pulse stretching and an
//            optional global brightness PWM (enabled by macro LED_PWM_EN).
// Revision : 1.0
// ============================================================================
module led_stretch_pwm #(
    parameter int WIDTH   = 12,
    parameter int STRETCH = 1000000,
    parameter int PWM_W   = 8,
    parameter int DUTY    = 64
) (
    input  wire logic         clk,
    input  wire logic         rst,
    led_stretch_pwm_if.slave  bus
);

    localparam int              c_CW     = (STRETCH > 0) ? $clog2(STRETCH + 1) : 1;
    localparam logic [c_CW-1:0] c_RELOAD = c_CW'(STRETCH);

    logic [WIDTH-1:0] r_in_q;
    logic [WIDTH-1:0] w_stretched;
    logic [WIDTH-1:0] r_led_out;
    logic             w_pwm_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_q <= '0;
        end else begin
            r_in_q <= bus.led_in;
        end
    end

    // Counter reloads while the bit is high, so retriggers extend without a gap.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [c_CW-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (r_in_q[i]) begin
                    r_cnt <= c_RELOAD;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - c_CW'(1);
                end
            end

            assign w_stretched[i] = r_in_q[i] | (r_cnt != '0);
        end
    endgenerate

`ifdef LED_PWM_EN
    localparam bit             c_ALWAYS_ON = (DUTY >= (1 << PWM_W));
    localparam logic [PWM_W:0] c_DUTY      = (PWM_W + 1)'(DUTY);

    logic [PWM_W-1:0] r_pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
        end
    end

    // Saturating duties are decided at elaboration, so truncation of c_DUTY is harmless.
    assign w_pwm_on = c_ALWAYS_ON | ({1'b0, r_pwm_cnt} < c_DUTY);
`else
    wire logic w_unused_cfg = ^{PWM_W[0], DUTY[0]};

    assign w_pwm_on = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led_out <= '0;
        end else begin
            r_led_out <= w_stretched & {WIDTH{w_pwm_on}};
        end
    end

    assign bus.led_out = r_led_out;

endmodule
`default_nettype wire

// File: tb/tb_led_stretch_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_stretch_pwm
// Brief    : Randomized self-checking bench for led_stretch_pwm, several
//            parameter sets side by side against a window-based reference.
// Revision : 1.0
// ============================================================================
module tb_led_stretch_pwm;

    localparam int W    = 12;
    localparam int PW   = 3;
    localparam int MAXE = 1024;
`ifdef LED_PWM_EN
    localparam bit c_PWM = 1'b1;
`else
    localparam bit c_PWM = 1'b0;
`endif

    logic         clk    = 1'b0;
    logic         rst    = 1'b1;
    logic [W-1:0] led_in = '1;

    always #5 clk = ~clk;

    // History of what each edge sampled, indexed by edge number (first edge = 1).
    int           ec = 0;
    logic [W-1:0] v_h   [MAXE];
    bit           rst_h [MAXE];

    always @(posedge clk) begin
        v_h[ec + 1]   <= led_in;
        rst_h[ec + 1] <= rst;
        ec            <= ec + 1;
    end

    led_stretch_pwm_if #(.WIDTH(W)) if_a ();
    led_stretch_pwm_if #(.WIDTH(W)) if_b ();
    led_stretch_pwm_if #(.WIDTH(W)) if_c ();
    led_stretch_pwm_if #(.WIDTH(W)) if_d ();
    led_stretch_pwm_if #(.WIDTH(W)) if_e ();

    assign if_a.led_in = led_in;
    assign if_b.led_in = led_in;
    assign if_c.led_in = led_in;
    assign if_d.led_in = led_in;
    assign if_e.led_in = led_in;

    led_stretch_pwm #(.WIDTH(W), .STRETCH(4), .PWM_W(PW), .DUTY(8))   u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    led_stretch_pwm #(.WIDTH(W), .STRETCH(0), .PWM_W(PW), .DUTY(8))   u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    led_stretch_pwm #(.WIDTH(W), .STRETCH(4), .PWM_W(PW), .DUTY(3))   u_c (.clk(clk), .rst(rst), .bus(if_c.slave));
    led_stretch_pwm #(.WIDTH(W), .STRETCH(4), .PWM_W(PW), .DUTY(0))   u_d (.clk(clk), .rst(rst), .bus(if_d.slave));
    led_stretch_pwm #(.WIDTH(W), .STRETCH(4), .PWM_W(PW), .DUTY(100)) u_e (.clk(clk), .rst(rst), .bus(if_e.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s edge=%0d got=%h exp=%h", tag, ec, got, exp);
        end
    endtask

    // Output after edge n is high for a bit if that bit was sampled high at any
    // edge in [n-1-s, n-1] since the last reset edge; PWM phase counts from reset.
    function automatic logic [W-1:0] model(input int n, input int s, input int duty);
        logic [W-1:0] acc = '0;
        int           r   = 0;
        bit           on;
        if (rst_h[n]) return '0;
        for (int j = n - 1; j >= 1 && j >= n - 1 - s; j--) begin
            if (rst_h[j]) break;
            acc |= v_h[j];
        end
        if (!c_PWM) return acc;
        for (int j = n - 1; j >= 1; j--) begin
            if (rst_h[j]) begin
                r = j;
                break;
            end
        end
        on = ((n - 1 - r) % (1 << PW)) < duty;
        return on ? acc : '0;
    endfunction

    task automatic step(input bit r, input logic [W-1:0] v);
        rst    = r;
        led_in = v;
        @(posedge clk);
        @(negedge clk);
        check_eq("a_s4_d8",   if_a.led_out, model(ec, 4, 8));
        check_eq("b_s0_d8",   if_b.led_out, model(ec, 0, 8));
        check_eq("c_s4_d3",   if_c.led_out, model(ec, 4, 3));
        check_eq("d_s4_d0",   if_d.led_out, model(ec, 4, 0));
        check_eq("e_s4_d100", if_e.led_out, model(ec, 4, 100));
    endtask

    initial begin
        logic [W-1:0] rv;
        for (int i = 0; i < 3; i++) step(1'b1, '1);
        for (int i = 0; i < 3; i++) step(1'b0, '1);
        for (int i = 0; i < 8; i++) step(1'b0, '0);

        step(1'b0, 12'h001);
        for (int i = 0; i < 8; i++) step(1'b0, '0);

        step(1'b0, 12'h008);
        step(1'b0, '0);
        step(1'b0, '0);
        step(1'b0, 12'h008);
        for (int i = 0; i < 9; i++) step(1'b0, '0);

        // Reset lands while bit 0's counter is at 3.
        step(1'b0, 12'h001);
        step(1'b0, '0);
        step(1'b0, '0);
        step(1'b1, '0);
        for (int i = 0; i < 6; i++) step(1'b0, '0);

        for (int i = 0; i < 300; i++) begin
            rv = W'($urandom & $urandom & $urandom);
            if (i % 60 > 40) rv = W'($urandom);
            step($urandom_range(0, 39) == 0, rv);
        end

        for (int i = 0; i < 16; i++) step(1'b0, '1);
        for (int i = 0; i < 8; i++) step(1'b0, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
